pearson_nonce_miner: RTL

- Sequencer directly upstream of the 64-bit Pearson hash core; owns and drives that core's message, enable and synchronous reset.
- Forms each 64-bit message as {header, nonce}, runs one hash per nonce and compares the 8-bit hash against a target.
- Stops on the first nonce whose hash is less than or equal to the target, on nonce exhaustion, or on a hash timeout.
- Top-level proof-of-work loop for the coin datapath.

---
 rtl/pearson_nonce_miner.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pearson_nonce_miner.sv
// pearson_nonce_miner: drives a Pearson hash core over nonces until hash <= target, exhaustion or timeout.
// Optional macro PEARSON_MINER_ATTEMPTS_EN adds a saturating attempts counter output.
`default_nettype none

module pearson_nonce_miner #(
  parameter logic [31:0] MAX_NONCE    = 32'hFFFF_FFFF,
  parameter int          CLEAR_CYCLES = 2,
  parameter int          TIMEOUT      = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] header,
  input  logic [31:0] nonce_init,
  input  logic [7:0]  target,
  input  logic [7:0]  hash_in,
  input  logic        hash_finished,
  output logic [63:0] hash_message,
  output logic        hash_enable,
  output logic        hash_reset_n,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        timeout_err,
  output logic [31:0] nonce_out,
`ifdef PEARSON_MINER_ATTEMPTS_EN
  output logic [31:0] attempts,
`endif
  output logic [7:0]  hash_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int CW = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_CLR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_clr_cnt;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_header_q;
  logic [31:0]   r_nonce_q;
  logic [7:0]    r_target_q;
  logic [7:0]    r_hash_q;
  logic          r_found;
  logic          r_timeout;
  logic [31:0]   r_nonce_out;
  logic [7:0]    r_hash_out;
  logic          w_start_ok;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_clr_cnt   <= '0;
      r_timer     <= '0;
      r_header_q  <= '0;
      r_nonce_q   <= '0;
      r_target_q  <= '0;
      r_hash_q    <= '0;
      r_found     <= 1'b0;
      r_timeout   <= 1'b0;
      r_nonce_out <= '0;
      r_hash_out  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_header_q <= header;
            r_nonce_q  <= nonce_init;
            r_target_q <= target;
            r_hash_q   <= '0;
            r_found    <= 1'b0;
            r_timeout  <= 1'b0;
            r_clr_cnt  <= c_CLR_LOAD;
            r_state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (r_clr_cnt == '0) begin
            r_timer <= '0;
            r_state <= RUN;
          end else begin
            r_clr_cnt <= r_clr_cnt - 1'b1;
          end
        end
        RUN: begin
          // A finish on the expiring cycle wins over the timeout.
          if (hash_finished) begin
            r_hash_q <= hash_in;
            r_state  <= CHECK;
          end else if (r_timer == c_TO_LAST) begin
            r_timeout   <= 1'b1;
            r_found     <= 1'b0;
            r_nonce_out <= r_nonce_q;
            r_hash_out  <= r_hash_q;
            r_state     <= DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        CHECK: begin
          // >= also stops a run whose first nonce already lies beyond MAX_NONCE.
          if (r_hash_q <= r_target_q) begin
            r_found     <= 1'b1;
            r_nonce_out <= r_nonce_q;
            r_hash_out  <= r_hash_q;
            r_state     <= DONE;
          end else if (r_nonce_q >= MAX_NONCE) begin
            r_found     <= 1'b0;
            r_nonce_out <= r_nonce_q;
            r_hash_out  <= r_hash_q;
            r_state     <= DONE;
          end else begin
            r_nonce_q <= r_nonce_q + 32'd1;
            r_clr_cnt <= c_CLR_LOAD;
            r_state   <= CLEAR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PEARSON_MINER_ATTEMPTS_EN
  logic [31:0] r_attempts;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_attempts <= '0;
    end else if (w_start_ok) begin
      r_attempts <= '0;
    end else if ((r_state == RUN) && hash_finished && (r_attempts != 32'hFFFF_FFFF)) begin
      r_attempts <= r_attempts + 32'd1;
    end
  end

  assign attempts = r_attempts;
`endif

  assign hash_message = {r_header_q, r_nonce_q};
  assign hash_enable  = (r_state == RUN);
  assign hash_reset_n = (r_state == RUN) || (r_state == CHECK);
  assign busy         = (r_state != IDLE) && (r_state != DONE);
  assign done         = (r_state == DONE);
  assign found        = r_found;
  assign timeout_err  = r_timeout;
  assign nonce_out    = r_nonce_out;
  assign hash_out     = r_hash_out;

endmodule

`default_nettype wire
